// File: rtl/cla_seq_adder_if.sv
// Operand/result handshake bundle for the sequential carry-lookahead adder.
// The adder takes the slave side; the producer/consumer takes the master side.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_1;
  logic [WIDTH-1:0] i_add_2;
  logic             i_carry;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH:0]   op_result;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_add_1, i_add_2, i_carry, i_sub, i_ready,
    output o_ready, o_valid, op_result, o_overflow
  );

  modport master (
    output i_valid, i_add_1, i_add_2, i_carry, i_sub, i_ready,
    input  o_ready, o_valid, op_result, o_overflow
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder/subtractor: one GROUP-bit carry-lookahead slice per cycle,
// slice carry held in a register, valid/ready handshakes on both sides.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  cla_seq_adder_if.slave  bus
);
  localparam int NSEG = WIDTH / GROUP;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [GROUP-1:0] sa, sb, g, p, s;
  logic [GROUP:0]   gx;
  logic [GROUP:0]   c;
  logic             prod;
  logic             cv;

  assign sa = a_q[cnt_q*GROUP +: GROUP];
  assign sb = b_q[cnt_q*GROUP +: GROUP];
  assign gx = {g, carry_q};

  for (genvar gi = 0; gi < GROUP; gi++) begin : g_bit
    assign g[gi] = sa[gi] & sb[gi];
    assign p[gi] = sa[gi] | sb[gi];
    assign s[gi] = sa[gi] ^ sb[gi] ^ c[gi];
  end

  // Each carry is a flat sum of products: generate at bit j (or slice cin)
  // ANDed with every propagate above it, so no carry depends on another.
  always_comb begin
    c    = '0;
    prod = 1'b0;
    cv   = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < GROUP; i++) begin
      cv = 1'b0;
      for (int j = 0; j <= i + 1; j++) begin
        prod = gx[j];
        for (int m = j; m <= i; m++) begin
          prod = prod & p[m];
        end
        cv = cv | prod;
      end
      c[i+1] = cv;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_add_1;
          b_d     = bus.i_sub ? ~bus.i_add_2 : bus.i_add_2;
          carry_d = bus.i_sub ^ bus.i_carry;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[cnt_q*GROUP +: GROUP] = s;
        carry_d = c[GROUP];
        if (cnt_q == CW'(NSEG - 1)) begin
          cout_d  = c[GROUP];
          ovf_d   = c[GROUP] ^ c[GROUP-1];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_ready    = (state_q == IDLE) & i_rst_n;
  assign bus.o_valid    = (state_q == DONE);
  assign bus.op_result  = {cout_q, sum_q};
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed-vector bench for cla_seq_adder at GROUP=4, 16 and 1 (WIDTH=16).
module tb_cla_seq_adder;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cla_seq_adder_if #(.WIDTH(16)) bus4 ();
  cla_seq_adder_if #(.WIDTH(16)) bus16 ();
  cla_seq_adder_if #(.WIDTH(16)) bus1 ();

  cla_seq_adder #(.WIDTH(16), .GROUP(4))  dut4  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));
  cla_seq_adder #(.WIDTH(16), .GROUP(16)) dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));
  cla_seq_adder #(.WIDTH(16), .GROUP(1))  dut1  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    case (sel)
      0: begin bus4.i_valid = v; bus4.i_add_1 = a; bus4.i_add_2 = b; bus4.i_carry = cin; bus4.i_sub = sub; end
      1: begin bus16.i_valid = v; bus16.i_add_1 = a; bus16.i_add_2 = b; bus16.i_carry = cin; bus16.i_sub = sub; end
      default: begin bus1.i_valid = v; bus1.i_add_1 = a; bus1.i_add_2 = b; bus1.i_carry = cin; bus1.i_sub = sub; end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic r);
    case (sel)
      0: bus4.i_ready = r;
      1: bus16.i_ready = r;
      default: bus1.i_ready = r;
    endcase
  endtask

  function automatic logic get_valid(input int sel);
    case (sel)
      0: return bus4.o_valid;
      1: return bus16.o_valid;
      default: return bus1.o_valid;
    endcase
  endfunction

  function automatic logic [16:0] get_res(input int sel);
    case (sel)
      0: return bus4.op_result;
      1: return bus16.op_result;
      default: return bus1.op_result;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return bus4.o_overflow;
      1: return bus16.o_overflow;
      default: return bus1.o_overflow;
    endcase
  endfunction

  // Drives one request, counts edges until o_valid (capped at 40), optionally completes the handshake.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input bit hold, output int lat, output logic [16:0] res,
                       output logic ovf);
    @(negedge clk);
    set_in(sel, 1'b1, a, b, cin, sub);
    @(posedge clk);
    #1;
    set_in(sel, 1'b0, a, b, cin, sub);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!get_valid(sel) && lat < 40);
    res = get_res(sel);
    ovf = get_ovf(sel);
    $display("txn dut%0d: a=%h b=%h cin=%0d sub=%0d -> result=%h ovf=%0d latency=%0d",
             sel, a, b, cin, sub, res, ovf, lat);
    if (!hold) begin
      @(negedge clk);
      set_ready(sel, 1'b1);
      @(posedge clk);
      #1;
      set_ready(sel, 1'b0);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready_held: got %0d want 0", bus4.o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %0d want 1", bus4.o_ready);
    end
    vectors++;
    if (bus4.o_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %0d want 0", bus4.o_valid);
    end
    vectors++;
    if (bus4.op_result !== 17'h00000 || bus4.o_overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_result: got %h/%0d want 00000/0", bus4.op_result, bus4.o_overflow);
    end
  endtask

  task automatic test_basic;
    int lat; logic [16:0] res; logic ovf;
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d want 4", lat); end
    vectors++;
    if (res !== 17'h00100 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL basic_add: got %h/%0d want 00100/0", res, ovf);
    end
  endtask

  task automatic test_propagate;
    int lat; logic [16:0] res; logic ovf;
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h10000 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL full_propagate: got %h/%0d want 10000/0", res, ovf);
    end
    do_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h00001 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL carry_in_only: got %h/%0d want 00001/0", res, ovf);
    end
  endtask

  task automatic test_overflow;
    int lat; logic [16:0] res; logic ovf;
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h08000 || ovf !== 1'b1) begin
      miscompares++; $display("FAIL signed_overflow: got %h/%0d want 08000/1", res, ovf);
    end
  endtask

  task automatic test_subtract;
    int lat; logic [16:0] res; logic ovf;
    do_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h0FFFE || ovf !== 1'b0) begin
      miscompares++; $display("FAIL sub_borrow: got %h/%0d want 0fffe/0", res, ovf);
    end
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h17FFF || ovf !== 1'b1) begin
      miscompares++; $display("FAIL sub_overflow: got %h/%0d want 17fff/1", res, ovf);
    end
    do_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h1000E) begin
      miscompares++; $display("FAIL sub_borrow_in: got %h want 1000e", res);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [16:0] res; logic ovf;
    do_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, lat, res, ovf);
    vectors++;
    if (res !== 17'h03333) begin miscompares++; $display("FAIL bp_result: got %h want 03333", res); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) set_in(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      if (i == 5) set_in(0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      vectors++;
      if (bus4.o_valid !== 1'b1 || bus4.op_result !== 17'h03333 || bus4.o_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%0d result=%h ready=%0d want 1/03333/0",
                 i, bus4.o_valid, bus4.op_result, bus4.o_ready);
      end
    end
    @(negedge clk);
    bus4.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus4.i_ready = 1'b0;
    vectors++;
    if (bus4.o_valid !== 1'b0 || bus4.o_ready !== 1'b1 || bus4.op_result !== 17'h03333) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%0d ready=%0d result=%h want 0/1/03333",
               bus4.o_valid, bus4.o_ready, bus4.op_result);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_valid !== 1'b0 || bus4.o_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_ignored_request: got valid=%0d ready=%0d want 0/1", bus4.o_valid, bus4.o_ready);
    end
    do_op(0, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h00005) begin miscompares++; $display("FAIL bp_fresh_op: got %h want 00005", res); end
  endtask

  task automatic test_mid_reset;
    int lat; logic [16:0] res; logic ovf;
    @(negedge clk);
    set_in(0, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_valid !== 1'b0 || bus4.op_result !== 17'h00000 || bus4.o_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_held: got valid=%0d result=%h ready=%0d want 0/00000/0",
               bus4.o_valid, bus4.op_result, bus4.o_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_valid !== 1'b0 || bus4.op_result !== 17'h00000 || bus4.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_release: got valid=%0d result=%h ready=%0d want 0/00000/1",
               bus4.o_valid, bus4.op_result, bus4.o_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus4.o_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_no_result: got %0d want 0", bus4.o_valid); end
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h02345) begin miscompares++; $display("FAIL midreset_next_op: got %h want 02345", res); end
  endtask

  task automatic test_group16;
    int lat; logic [16:0] res; logic ovf;
    do_op(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL g16_latency: got %0d want 1", lat); end
    vectors++;
    if (res !== 17'h00100 || ovf !== 1'b0) begin miscompares++; $display("FAIL g16_add: got %h/%0d want 00100/0", res, ovf); end
    do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h08000 || ovf !== 1'b1) begin miscompares++; $display("FAIL g16_overflow: got %h/%0d want 08000/1", res, ovf); end
  endtask

  task automatic test_group1;
    int lat; logic [16:0] res; logic ovf;
    do_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, res, ovf);
    vectors++;
    if (lat !== 16) begin miscompares++; $display("FAIL g1_latency: got %0d want 16", lat); end
    vectors++;
    if (res !== 17'h00100 || ovf !== 1'b0) begin miscompares++; $display("FAIL g1_add: got %h/%0d want 00100/0", res, ovf); end
    do_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, lat, res, ovf);
    vectors++;
    if (res !== 17'h17FFF || ovf !== 1'b1) begin miscompares++; $display("FAIL g1_sub: got %h/%0d want 17fff/1", res, ovf); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_in(s, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      set_ready(s, 1'b0);
    end
    test_reset();
    test_basic();
    test_propagate();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_mid_reset();
    test_group16();
    test_group1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
